// File: rtl/alarm_scheduler.sv
// Alarm clock scheduler: daily alarm FSM (idle / ringing / snoozed),
// hourly chime in the last five seconds of each hour, and a registered
// buzzer drive that lets the chime preempt the alarm beep.
// State is visible on the ringing / snoozed outputs (both low = IDLE).
module alarm_scheduler #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
) (
  input  logic       clk_2kHz,
  input  logic       rst_n,
  input  logic       sec_tick,
  input  logic [3:0] h_cntH,
  input  logic [3:0] h_cntL,
  input  logic [3:0] m_cntH,
  input  logic [3:0] m_cntL,
  input  logic [3:0] s_cntH,
  input  logic [3:0] s_cntL,
  input  logic [3:0] al_hH,
  input  logic [3:0] al_hL,
  input  logic [3:0] al_mH,
  input  logic [3:0] al_mL,
  input  logic       alarm_en,
  input  logic       stop_key,
  input  logic       snooze_key,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozed,
  output logic       chime_active
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } state_e;

  // Terminal counts: the transition fires on the tick that would complete the interval.
  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);
  localparam logic [9:0] SNZ_LAST  = 10'(SNOOZE_SECS - 1);

  state_e     state_q, state_d;
  logic [7:0] ring_cnt_q, ring_cnt_d;
  logic [9:0] snz_cnt_q, snz_cnt_d;
  logic       beep_on_q, beep_on_d;
  logic       armed_q, armed_d;
  logic [1:0] tone_cnt_q;
  logic       buzzer_q, buzzer_d;

  logic [7:0] mins;
  logic [7:0] secs;
  logic       match_hm;
  logic       trigger;
  logic       tone_1k;
  logic       tone_500;
  logic       chime_low;
  logic       chime_high;
  logic       chime_tone;

  assign mins     = {m_cntH, m_cntL};
  assign secs     = {s_cntH, s_cntL};
  assign match_hm = ({h_cntH, h_cntL, m_cntH, m_cntL} == {al_hH, al_hL, al_mH, al_mL});

  assign tone_1k  = tone_cnt_q[0];
  assign tone_500 = tone_cnt_q[1];

  // xx:59:55..58 -> low tone, xx:59:59 -> high tone; purely from the time inputs.
  assign chime_low    = (mins == 8'h59) && (secs >= 8'h55) && (secs <= 8'h58);
  assign chime_high   = (mins == 8'h59) && (secs == 8'h59);
  assign chime_active = chime_low | chime_high;
  assign chime_tone   = chime_high ? tone_1k : tone_500;

  // Free-running tone divider.
  always_ff @(posedge clk_2kHz) begin
    if (!rst_n) begin
      tone_cnt_q <= 2'd0;
    end else begin
      tone_cnt_q <= tone_cnt_q + 2'd1;
    end
  end

  // Next-state logic: stop / disable beats snooze, snooze beats the second tick.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    beep_on_d  = beep_on_q;
    trigger    = 1'b0;
    case (state_q)
      IDLE: begin
        if (alarm_en && armed_q && match_hm && (secs == 8'h00)) begin
          trigger    = 1'b1;
          state_d    = RINGING;
          ring_cnt_d = 8'd0;
          beep_on_d  = 1'b1;
        end
      end
      RINGING: begin
        if (stop_key || !alarm_en) begin
          state_d   = IDLE;
          beep_on_d = 1'b0;
        end else if (snooze_key) begin
          state_d   = SNOOZED;
          snz_cnt_d = 10'd0;
        end else if (sec_tick) begin
          if (ring_cnt_q == RING_LAST) begin
            state_d   = IDLE;
            beep_on_d = 1'b0;
          end else begin
            ring_cnt_d = ring_cnt_q + 8'd1;
            beep_on_d  = ~beep_on_q;
          end
        end
      end
      SNOOZED: begin
        if (stop_key || !alarm_en) begin
          state_d   = IDLE;
          beep_on_d = 1'b0;
        end else if (sec_tick) begin
          if (snz_cnt_q == SNZ_LAST) begin
            state_d    = RINGING;
            ring_cnt_d = 8'd0;
            beep_on_d  = 1'b1;
          end else begin
            snz_cnt_d = snz_cnt_q + 10'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // One trigger per match minute: re-arm only once the time leaves the alarm minute.
  always_comb begin
    armed_d = armed_q;
    if (trigger) begin
      armed_d = 1'b0;
    end else if (!match_hm) begin
      armed_d = 1'b1;
    end
  end

  // Buzzer arbitration: chime preempts the alarm beep without touching the FSM.
  always_comb begin
    buzzer_d = 1'b0;
    if (chime_active) begin
      buzzer_d = chime_tone;
    end else if ((state_q == RINGING) && beep_on_q) begin
      buzzer_d = tone_1k;
    end
  end

  // FSM state, counters and arming flag.
  always_ff @(posedge clk_2kHz) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ring_cnt_q <= 8'd0;
      snz_cnt_q  <= 10'd0;
      beep_on_q  <= 1'b0;
      armed_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      beep_on_q  <= beep_on_d;
      armed_q    <= armed_d;
    end
  end

  // Registered speaker drive.
  always_ff @(posedge clk_2kHz) begin
    if (!rst_n) begin
      buzzer_q <= 1'b0;
    end else begin
      buzzer_q <= buzzer_d;
    end
  end

  assign buzzer  = buzzer_q;
  assign ringing = (state_q == RINGING);
  assign snoozed = (state_q == SNOOZED);

endmodule

// File: tb/tb_alarm_scheduler.sv
// Bench for alarm_scheduler: directed scenarios followed by a randomized run,
// all checked every cycle against a seconds-remaining reference model.
module tb_alarm_scheduler;

  localparam int RING = 60;
  localparam int SNZ  = 300;

  // ---------------- clock / reset ----------------
  logic clk_2kHz = 1'b0;
  always #5 clk_2kHz = ~clk_2kHz;

  logic rst_n;
  logic sec_tick;
  logic alarm_en;
  logic stop_key;
  logic snooze_key;

  int cur_h = 0;
  int cur_m = 0;
  int cur_s = 0;
  int al_h  = 0;
  int al_m  = 0;

  logic [3:0] h_cntH, h_cntL, m_cntH, m_cntL, s_cntH, s_cntL;
  logic [3:0] al_hH, al_hL, al_mH, al_mL;
  logic       buzzer, ringing, snoozed, chime_active;

  assign h_cntH = 4'(cur_h / 10);
  assign h_cntL = 4'(cur_h % 10);
  assign m_cntH = 4'(cur_m / 10);
  assign m_cntL = 4'(cur_m % 10);
  assign s_cntH = 4'(cur_s / 10);
  assign s_cntL = 4'(cur_s % 10);
  assign al_hH  = 4'(al_h / 10);
  assign al_hL  = 4'(al_h % 10);
  assign al_mH  = 4'(al_m / 10);
  assign al_mL  = 4'(al_m % 10);

  alarm_scheduler #(.RING_SECS(RING), .SNOOZE_SECS(SNZ)) dut (
    .clk_2kHz    (clk_2kHz),
    .rst_n       (rst_n),
    .sec_tick    (sec_tick),
    .h_cntH      (h_cntH),
    .h_cntL      (h_cntL),
    .m_cntH      (m_cntH),
    .m_cntL      (m_cntL),
    .s_cntH      (s_cntH),
    .s_cntL      (s_cntL),
    .al_hH       (al_hH),
    .al_hL       (al_hL),
    .al_mH       (al_mH),
    .al_mL       (al_mL),
    .alarm_en    (alarm_en),
    .stop_key    (stop_key),
    .snooze_key  (snooze_key),
    .buzzer      (buzzer),
    .ringing     (ringing),
    .snoozed     (snoozed),
    .chime_active(chime_active)
  );

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 ringing, 2 snoozed. Intervals are tracked as seconds remaining.
  int   m_mode      = 0;
  int   m_ring_left = 0;
  int   m_snz_left  = 0;
  bit   m_fired     = 1'b0;
  int   m_cyc       = 0;
  logic m_buzz      = 1'b0;

  logic [3:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  function automatic bit in_chime();
    return (cur_m == 59) && (cur_s >= 55);
  endfunction

  task automatic model_edge();
    bit match, trig, t1k, t500, beep;
    if (!rst_n) begin
      m_mode = 0; m_ring_left = 0; m_snz_left = 0;
      m_fired = 1'b0; m_cyc = 0; m_buzz = 1'b0;
    end else begin
      t1k   = (m_cyc % 2) == 1;
      t500  = ((m_cyc / 2) % 2) == 1;
      match = (cur_h == al_h) && (cur_m == al_m);
      beep  = ((RING - m_ring_left) % 2) == 0;
      if (in_chime()) m_buzz = (cur_s == 59) ? t1k : t500;
      else if (m_mode == 1 && beep) m_buzz = t1k;
      else m_buzz = 1'b0;
      trig = 1'b0;
      if (m_mode == 0) begin
        if (alarm_en && !m_fired && match && cur_s == 0) begin
          trig = 1'b1; m_mode = 1; m_ring_left = RING;
        end
      end else if (stop_key || !alarm_en) begin
        m_mode = 0;
      end else if (m_mode == 1) begin
        if (snooze_key) begin
          m_mode = 2; m_snz_left = SNZ;
        end else if (sec_tick) begin
          m_ring_left--;
          if (m_ring_left == 0) m_mode = 0;
        end
      end else if (sec_tick) begin
        m_snz_left--;
        if (m_snz_left == 0) begin
          m_mode = 1; m_ring_left = RING;
        end
      end
      if (trig) m_fired = 1'b1;
      else if (!match) m_fired = 1'b0;
      m_cyc++;
    end
    exp_q.push_back({m_mode == 1, m_mode == 2, m_buzz, in_chime()});
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic got, input logic exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got %0b expected %0b at t=%0t", tag, got, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    logic [3:0] e;
    model_edge();
    @(posedge clk_2kHz);
    #1;
    e = exp_q.pop_front();
    check("ringing", ringing, e[3]);
    check("snoozed", snoozed, e[2]);
    check("buzzer", buzzer, e[1]);
    check("chime_active", chime_active, e[0]);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    step();
    sec_tick = 1'b0;
  endtask

  task automatic ticks(input int n, input int gap);
    repeat (n) begin
      tick();
      repeat (gap) step();
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cur_h = h; cur_m = m; cur_s = s;
  endtask

  task automatic set_alarm(input int h, input int m);
    al_h = h; al_m = m;
  endtask

  task automatic press_snooze();
    snooze_key = 1'b1;
    step();
    snooze_key = 1'b0;
  endtask

  task automatic press_stop();
    stop_key = 1'b1;
    step();
    stop_key = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int r;
    rst_n = 1'b0; sec_tick = 1'b0; alarm_en = 1'b0;
    stop_key = 1'b0; snooze_key = 1'b0;
    set_time(0, 0, 1); set_alarm(7, 30);
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // hourly chime: slow tone, fast tone, then silence on the hour
    set_time(12, 59, 55); idle(8);
    set_time(12, 59, 59); idle(6);
    set_time(13, 0, 0);   idle(4);

    // alarm 07:30 rings for RING seconds, no retrigger within the minute
    alarm_en = 1'b1;
    set_time(7, 30, 0); step();
    ticks(RING, 1);
    idle(5);
    set_time(7, 30, 17); idle(3);

    // snooze then automatic re-ring with a fresh count
    set_time(7, 31, 0); step();
    set_time(7, 30, 0); step();
    ticks(3, 1);
    press_snooze(); idle(3);
    press_snooze(); idle(2);
    ticks(SNZ, 0);
    ticks(4, 1);

    // stop and snooze together: stop wins
    stop_key = 1'b1; snooze_key = 1'b1; step();
    stop_key = 1'b0; snooze_key = 1'b0;
    idle(3);
    press_snooze(); press_stop(); idle(2);

    // chime preempts a ringing alarm at 08:59:55..59
    set_alarm(8, 59);
    set_time(8, 59, 0); step();
    ticks(2, 1);
    for (int s = 55; s <= 59; s++) begin
      set_time(8, 59, s);
      tick();
      idle(3);
    end
    set_time(9, 0, 0);
    ticks(RING, 1);
    idle(3);

    // alarm_en dropped while ringing, then while snoozed
    set_alarm(6, 0);
    set_time(6, 0, 0); step();
    ticks(2, 1);
    alarm_en = 1'b0; step(); alarm_en = 1'b1;
    idle(2);
    set_time(6, 1, 0); step();
    set_time(6, 0, 0); step();
    press_snooze(); idle(2);
    alarm_en = 1'b0; step(); alarm_en = 1'b1;
    idle(2);

    // reset during snooze aborts; no ring after the snooze interval
    set_alarm(10, 15);
    set_time(10, 15, 0); step();
    ticks(2, 1);
    press_snooze(); idle(2);
    set_time(10, 16, 0);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    ticks(SNZ + 5, 0);
    idle(3);

    // reset released while time sits on hh:mm:00 of the alarm -> triggers
    rst_n = 1'b0;
    set_alarm(11, 11); set_time(11, 11, 0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    press_stop(); idle(2);

    // randomized run
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 3) set_time(al_h, al_m, 0);
      else if (r < 6) set_time($urandom_range(0, 23), 59, $urandom_range(53, 59));
      else if (r < 9) set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      if ($urandom_range(0, 500) == 0) set_alarm($urandom_range(0, 23), $urandom_range(0, 59));
      sec_tick   = ($urandom_range(0, 2) == 0);
      stop_key   = ($urandom_range(0, 80) == 0);
      snooze_key = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 200) == 0) alarm_en = ~alarm_en;
      rst_n = ($urandom_range(0, 500) != 0);
      step();
    end
    rst_n = 1'b1; sec_tick = 1'b0; stop_key = 1'b0; snooze_key = 1'b0;
    idle(2);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
